// File: rtl/swan_pkg.sv
// Shared sizes, mode encodings and controller state type for the SWAN64 mode controller.
package swan_pkg;
    localparam int BLOCK_SIZE = 64;
    localparam int KEY_SIZE   = 128;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_e;
endpackage

// File: rtl/swan64_chain_reg.sv
// CBC chaining/IV register plus the pre-whitening XOR applied to incoming plaintext.
// Registered state, combinational whitening path; no flow control of its own.
module swan64_chain_reg
    import swan_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [0:BLOCK_SIZE-1] iv_i,
    input  logic                  mode_i,
    input  logic                  upd_i,
    input  logic [0:BLOCK_SIZE-1] upd_dat_i,
    input  logic                  restore_i,
    input  logic [0:BLOCK_SIZE-1] blk_i,
    output logic [0:BLOCK_SIZE-1] blk_o
);
    logic [0:BLOCK_SIZE-1] iv_q;
    logic [0:BLOCK_SIZE-1] chain_q;
    logic [0:BLOCK_SIZE-1] chain_d;

    // A config load restarts chaining; end-of-message or abort rewinds to the stored IV.
    always_comb begin
        chain_d = chain_q;
        if (load_i) begin
            chain_d = iv_i;
        end else if (restore_i) begin
            chain_d = iv_q;
        end else if (upd_i) begin
            chain_d = upd_dat_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iv_q    <= '0;
            chain_q <= '0;
        end else begin
            if (load_i) begin
                iv_q <= iv_i;
            end
            chain_q <= chain_d;
        end
    end

    assign blk_o = (mode_i == MODE_CBC) ? (blk_i ^ chain_q) : blk_i;
endmodule

// File: rtl/swan64_mode_ctrl.sv
// ECB/CBC sequencer for one serial SWAN64K128 core, one block in flight; out_valid at T+2+L.
// Optional RUN watchdog with sticky err under `SWAN_CTRL_TIMEOUT_EN.
module swan64_mode_ctrl
    import swan_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:KEY_SIZE-1]   cfg_key,
    input  logic [0:BLOCK_SIZE-1] cfg_iv,
    input  logic                  cfg_mode,
    input  logic                  cfg_load,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:BLOCK_SIZE-1] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:BLOCK_SIZE-1] out_data,
    output logic                  out_last,
    output logic [CNT_W-1:0]      blk_cnt,
    output logic                  busy,
    output logic                  err,
    output logic                  core_start,
    output logic [0:KEY_SIZE-1]   core_key,
    output logic [0:BLOCK_SIZE-1] core_inp,
    input  logic                  core_ready,
    input  logic [0:BLOCK_SIZE-1] core_out
);
    state_e                state_q, state_d;
    logic [0:KEY_SIZE-1]   key_q;
    logic                  mode_q;
    logic [0:BLOCK_SIZE-1] core_inp_q;
    logic [0:BLOCK_SIZE-1] out_data_q;
    logic [0:BLOCK_SIZE-1] whitened;
    logic                  last_q;
    logic                  out_last_q;
    logic [CNT_W-1:0]      blk_cnt_q;
    logic                  cfg_take;
    logic                  in_hs;
    logic                  core_done;
    logic                  out_hs;
    logic                  msg_end;
    logic                  timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign cfg_take  = (state_q == IDLE) && cfg_load;
    assign in_ready  = (state_q == IDLE) && !cfg_load && !rst;
    assign in_hs     = in_valid && in_ready;
    assign core_done = (state_q == RUN) && core_ready;
    assign out_hs    = (state_q == HOLD) && out_ready;
    assign msg_end   = out_hs && out_last_q;

`ifdef SWAN_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign timeout = (state_q == RUN) && !core_ready && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == RUN) ? tmo_q + 1'b1 : '0;
            if (cfg_take) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_hs) state_d = START;
            START:   state_d = RUN;
            RUN: begin
                if (core_done) begin
                    state_d = HOLD;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q      <= '0;
            mode_q     <= MODE_ECB;
            core_inp_q <= '0;
            last_q     <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            if (cfg_take) begin
                key_q  <= cfg_key;
                mode_q <= cfg_mode;
            end
            // core_inp stays put from START until the core answers.
            if (in_hs) begin
                core_inp_q <= whitened;
                last_q     <= in_last;
            end
            if (core_done) begin
                out_data_q <= core_out;
                out_last_q <= last_q;
            end else if (out_hs) begin
                out_last_q <= 1'b0;
            end
            if (cfg_take || msg_end || timeout) begin
                blk_cnt_q <= '0;
            end else if (out_hs) begin
                blk_cnt_q <= blk_cnt_q + 1'b1;
            end
        end
    end

    swan64_chain_reg u_chain (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cfg_take),
        .iv_i      (cfg_iv),
        .mode_i    (mode_q),
        .upd_i     (core_done && (mode_q == MODE_CBC)),
        .upd_dat_i (core_out),
        .restore_i (msg_end || timeout),
        .blk_i     (in_data),
        .blk_o     (whitened)
    );

    assign out_valid  = (state_q == HOLD);
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign blk_cnt    = blk_cnt_q;
    assign busy       = (state_q != IDLE);
    assign core_start = (state_q == START);
    assign core_key   = key_q;
    assign core_inp   = core_inp_q;
endmodule
